// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem timer: register map, CTRL bit layout,
// bus FSM states and the byte-lane write helper.
package iomem_timer_pkg;

   // Register offsets within the 256-byte window (word aligned).
   localparam logic [7:0] TMR_CTRL     = 8'h00;
   localparam logic [7:0] TMR_PRESCALE = 8'h04;
   localparam logic [7:0] TMR_COMPARE  = 8'h08;
   localparam logic [7:0] TMR_COUNT    = 8'h0C;
   localparam logic [7:0] TMR_STATUS   = 8'h10;

   // CTRL bit positions.
   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // Bus handshake: accept a request, then spend one cycle acknowledging it.
   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

   // Merge new data into an old word, one byte per asserted strobe.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wstrb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// Clock prescaler: counts 0..prescale while enabled and emits a one-cycle
// tick on the terminal value; held at zero while disabled or cleared.
module iomem_timer_prescaler (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   input  logic [15:0] prescale,
   output logic        tick
);

   logic [15:0] pcnt;

   assign tick = en && (pcnt == prescale);

   // Advance the prescale counter, wrapping on tick.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt <= '0;
      end else if (!en || clr || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 16'd1;
      end
   end

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit timer/compare peripheral on the iomem bus with a
// level interrupt (MATCH & IRQ_EN).
module iomem_timer
   import iomem_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);

   bus_state_e  state, state_nxt;
   logic        hit, access, wr_en;
   logic [7:0]  offset;
   logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;

   logic        ctrl_en, ctrl_auto, ctrl_irq_en;
   logic [15:0] prescale;
   logic [31:0] compare, count;
   logic        match;
   logic        tick, match_tick;
   logic [31:0] rd_val;

   // Byte offset bits [1:0] are don't-care for word registers.
   logic        addr_lsb_unused;
   assign addr_lsb_unused = ^iomem_addr[1:0];

   assign hit    = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign offset = {iomem_addr[7:2], 2'b00};

   assign wr_en       = access && (iomem_wstrb != 4'b0000);
   assign wr_ctrl     = wr_en && (offset == TMR_CTRL);
   assign wr_prescale = wr_en && (offset == TMR_PRESCALE);
   assign wr_compare  = wr_en && (offset == TMR_COMPARE);
   assign wr_count    = wr_en && (offset == TMR_COUNT);
   assign wr_status   = wr_en && (offset == TMR_STATUS);

   assign match_tick = tick && (count == compare);
   assign irq        = match && ctrl_irq_en;

   iomem_timer_prescaler u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (ctrl_en),
      .clr      (wr_count),
      .prescale (prescale),
      .tick     (tick)
   );

   // Bus FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= BUS_IDLE;
      else       state <= state_nxt;
   end

   // Bus FSM next state: accept a hit only from IDLE so a held request is taken once per two cycles.
   // NOTE: defaults are assigned first so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      access      = 1'b0;
      iomem_ready = 1'b0;
      case (state)
         BUS_IDLE: begin
            if (hit) begin
               access    = 1'b1;
               state_nxt = BUS_ACK;
            end
         end
         BUS_ACK: begin
            iomem_ready = 1'b1;
            state_nxt   = BUS_IDLE;
         end
      endcase
   end

   // Read mux over the register contents of the request cycle.
   always_comb begin
      rd_val = '0;
      case (offset)
         TMR_CTRL: begin
            rd_val[CTRL_EN]     = ctrl_en;
            rd_val[CTRL_AUTO]   = ctrl_auto;
            rd_val[CTRL_IRQ_EN] = ctrl_irq_en;
         end
         TMR_PRESCALE: rd_val[15:0] = prescale;
         TMR_COMPARE:  rd_val       = compare;
         TMR_COUNT:    rd_val       = count;
         TMR_STATUS:   rd_val[0]    = match;
         default:      rd_val       = '0;
      endcase
   end

   // Registered read data, zero whenever no acknowledge follows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       iomem_rdata <= '0;
      else if (access) iomem_rdata <= rd_val;
      else             iomem_rdata <= '0;
   end

   // Register file and compare logic; bus writes take priority over timer events
   // except that a match set beats a STATUS clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_en     <= 1'b0;
         ctrl_auto   <= 1'b0;
         ctrl_irq_en <= 1'b0;
         prescale    <= '0;
         compare     <= '0;
         count       <= '0;
         match       <= 1'b0;
      end else begin
         if (wr_ctrl && iomem_wstrb[0]) begin
            ctrl_en     <= iomem_wdata[CTRL_EN];
            ctrl_auto   <= iomem_wdata[CTRL_AUTO];
            ctrl_irq_en <= iomem_wdata[CTRL_IRQ_EN];
         end else if (match_tick && !ctrl_auto) begin
            ctrl_en <= 1'b0;
         end

         if (wr_prescale) begin
            if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
         end

         if (wr_compare) compare <= apply_wstrb(compare, iomem_wdata, iomem_wstrb);

         if (wr_count)        count <= apply_wstrb(count, iomem_wdata, iomem_wstrb);
         else if (match_tick) count <= '0;
         else if (tick)       count <= count + 32'd1;

         if (match_tick)
            match <= 1'b1;
         else if (wr_status && iomem_wstrb[0] && iomem_wdata[0])
            match <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iomem_timer.sv
// Self-checking bench for iomem_timer: bus tasks push expected read data to a
// scoreboard queue, a negedge monitor pops and compares on each acknowledge.
module tb_iomem_timer;
   import iomem_timer_pkg::*;

   localparam logic [31:0] BASE = 32'h0300_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        irq;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      logic [7:0]  off;
   } exp_t;

   exp_t sb[$];

   iomem_timer #(.BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every acknowledge must match the oldest expectation.
   always @(negedge clk) begin
      if (iomem_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack rdata=%h required no ack", iomem_rdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) begin
               checks++;
               if (iomem_rdata !== e.exp) begin
                  errors++;
                  $display("FAIL rdata off=%h got %h required %h", e.off, iomem_rdata, e.exp);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // One complete request: drive, expect ack one cycle later, then idle.
   task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input logic chk,
                           input logic [31:0] exp);
      exp_t e;
      @(posedge clk); #1;
      e.chk = chk; e.exp = exp; e.off = addr[7:0];
      sb.push_back(e);
      iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = wstrb; iomem_wdata = wdata;
      checks++;
      if (iomem_ready !== 1'b0) begin
         errors++;
         $display("FAIL early_ready addr=%h got %b required 0", addr, iomem_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (iomem_ready !== 1'b1) begin
         errors++;
         $display("FAIL ack addr=%h got %b required 1", addr, iomem_ready);
      end
      iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin
         errors++;
         $display("FAIL ack_drop addr=%h got ready=%b rdata=%h required 0/0", addr, iomem_ready, iomem_rdata);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] data);
      bus_xfer(BASE + {24'd0, off}, 4'hF, data, 1'b0, 32'h0);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp);
      bus_xfer(BASE + {24'd0, off}, 4'h0, 32'h0, 1'b1, exp);
   endtask

   task automatic wait_irq(input int budget, output int unsigned at);
      bit found;
      found = 1'b0;
      at    = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(posedge clk); #1;
         if (irq === 1'b1) begin
            found = 1'b1;
            at    = cyc;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL irq_timeout got no irq required irq within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      iomem_addr = 32'h0; iomem_wdata = 32'h0;
      #2;
      checks++;
      if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%b rdata=%h irq=%b required 0", iomem_ready, iomem_rdata, irq);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      rd(TMR_CTRL, 32'h0);
      rd(TMR_PRESCALE, 32'h0);
      rd(TMR_COMPARE, 32'h0);
      rd(TMR_COUNT, 32'h0);
      rd(TMR_STATUS, 32'h0);
   endtask

   task automatic test_read_write();
      wr(TMR_COMPARE, 32'h1234_5678);
      rd(TMR_COMPARE, 32'h1234_5678);
      bus_xfer(BASE + {24'd0, TMR_COMPARE}, 4'b0010, 32'h0000_AA00, 1'b0, 32'h0);
      rd(TMR_COMPARE, 32'h1234_AA78);
   endtask

   task automatic test_auto_reload();
      int unsigned t0, r1, r2;
      wr(TMR_CTRL, 32'h0);
      wr(TMR_COUNT, 32'h0);
      wr(TMR_STATUS, 32'h1);
      wr(TMR_PRESCALE, 32'h0);
      wr(TMR_COMPARE, 32'h3);
      wr(TMR_CTRL, 32'h7);
      t0 = cyc;  // one edge after the CTRL write edge
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL auto_irq_early got %b required 0", irq);
      end
      wait_irq(20, r1);
      checks++;
      if (r1 - (t0 - 1) !== 32'd4) begin
         errors++;
         $display("FAIL auto_first_match got %0d cycles required 4", r1 - (t0 - 1));
      end
      wr(TMR_STATUS, 32'h1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL auto_irq_clear got %b required 0", irq);
      end
      wait_irq(20, r2);
      checks++;
      if (r2 - r1 !== 32'd4) begin
         errors++;
         $display("FAIL auto_period got %0d cycles required 4", r2 - r1);
      end
      wr(TMR_CTRL, 32'h0);
   endtask

   task automatic test_collision_status();
      wr(TMR_CTRL, 32'h0);
      wr(TMR_COUNT, 32'h0);
      wr(TMR_STATUS, 32'h1);
      wr(TMR_CTRL, 32'h7);       // match tick lands on the 4th edge after this write
      @(posedge clk);
      wr(TMR_STATUS, 32'h1);     // request edge coincides with the match tick
      rd(TMR_STATUS, 32'h1);
      wr(TMR_CTRL, 32'h0);
   endtask

   task automatic test_collision_count();
      wr(TMR_CTRL, 32'h0);
      wr(TMR_COUNT, 32'h0);
      wr(TMR_STATUS, 32'h1);
      wr(TMR_PRESCALE, 32'h4);
      wr(TMR_COMPARE, 32'hFFFF_FFFF);
      wr(TMR_CTRL, 32'h1);       // first tick on the 5th edge after this write
      repeat (2) @(posedge clk);
      wr(TMR_COUNT, 32'h10);     // request edge coincides with that tick
      rd(TMR_COUNT, 32'h10);     // prescaler restarted, next tick still ahead
      wr(TMR_CTRL, 32'h0);
   endtask

   task automatic test_one_shot();
      int unsigned t0, r1;
      wr(TMR_COUNT, 32'h0);
      wr(TMR_STATUS, 32'h1);
      wr(TMR_PRESCALE, 32'h2);
      wr(TMR_COMPARE, 32'h1);
      wr(TMR_CTRL, 32'h5);
      t0 = cyc;
      wait_irq(30, r1);
      checks++;
      if (r1 - (t0 - 1) !== 32'd6) begin
         errors++;
         $display("FAIL oneshot_delay got %0d cycles required 6", r1 - (t0 - 1));
      end
      rd(TMR_CTRL, 32'h4);
      rd(TMR_COUNT, 32'h0);
      repeat (10) @(posedge clk);
      rd(TMR_COUNT, 32'h0);
      rd(TMR_STATUS, 32'h1);
   endtask

   task automatic test_reset_midrun();
      wr(TMR_CTRL, 32'h7);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL midrun_irq_before got %b required 1", irq);
      end
      @(posedge clk); #1;
      iomem_valid = 1'b1; iomem_addr = BASE + {24'd0, TMR_COUNT}; iomem_wstrb = 4'h0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL midrun_async got ready=%b rdata=%h irq=%b required 0", iomem_ready, iomem_rdata, irq);
      end
      @(posedge clk); #1;
      checks++;
      if (iomem_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_ack got %b required 0", iomem_ready);
      end
      iomem_valid = 1'b0;
      @(negedge clk) reset = 1'b0;
      rd(TMR_CTRL, 32'h0);
      rd(TMR_PRESCALE, 32'h0);
      rd(TMR_COMPARE, 32'h0);
      rd(TMR_COUNT, 32'h0);
      rd(TMR_STATUS, 32'h0);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL midrun_irq_after got %b required 0", irq);
      end
   endtask

   task automatic test_decode();
      int saw;
      saw = 0;
      @(posedge clk); #1;
      iomem_valid = 1'b1; iomem_addr = 32'h0400_0010; iomem_wstrb = 4'h0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (iomem_ready !== 1'b0) saw++;
      end
      iomem_valid = 1'b0;
      checks++;
      if (saw !== 0) begin
         errors++;
         $display("FAIL miss_ack got %0d acks required 0", saw);
      end
      rd(8'h40, 32'h0);

      wr(TMR_COMPARE, 32'hCAFE_F00D);
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.chk = 1'b1; e.exp = 32'hCAFE_F00D; e.off = TMR_COMPARE;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      iomem_valid = 1'b1; iomem_addr = BASE + {24'd0, TMR_COMPARE}; iomem_wstrb = 4'h0;
      for (int k = 0; k < 5; k++) begin
         logic want;
         want = (k % 2 == 0);
         @(posedge clk); #1;
         checks++;
         if (iomem_ready !== want) begin
            errors++;
            $display("FAIL held_ack k=%0d got %b required %b", k, iomem_ready, want);
         end
      end
      iomem_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (iomem_ready !== 1'b0) begin
         errors++;
         $display("FAIL held_release got %b required 0", iomem_ready);
      end
   endtask

   initial begin
      test_reset();
      test_read_write();
      test_auto_reload();
      test_collision_status();
      test_collision_count();
      test_one_shot();
      test_reset_midrun();
      test_decode();
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d entries required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped 32-bit timer/compare peripheral on the SoC's external `iomem_*` bus, answering a 256-byte window above the on-chip UART/flash-config space. It consumes CPU loads and stores forwarded to the iomem port and produces a level interrupt wired to the SoC's `irq_5` input. It gives firmware a periodic tick and one-shot delays without polling the cycle counter.

## Interface
- `BASE_ADDR`, default 32'h0300_0000: window base; bits [7:0] must be zero.
- `clk`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset; deassertion synchronous to `clk`.
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  one-cycle acknowledge for a request that hits the window.
- `iomem_wstrb`  in  4  byte write enables; 0 = read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid only while `iomem_ready`=1, 0 otherwise.
- `irq`  out  1  level interrupt = `MATCH & IRQ_EN`.

## Operation
- Hit: `iomem_valid && iomem_addr[31:8]==BASE_ADDR[31:8]`. Misses are ignored; `iomem_ready` stays 0.
- Registers, offset = `addr[7:0]`; `addr[1:0]` ignored:
  - 0x00 CTRL: bit0 `EN`, bit1 `AUTO` (auto-reload), bit2 `IRQ_EN`; other bits read 0.
  - 0x04 PRESCALE [15:0]; bits [31:16] read 0.
  - 0x08 COMPARE [31:0].
  - 0x0C COUNT [31:0]; a write loads the counter and clears the prescaler.
  - 0x10 STATUS: bit0 `MATCH`; write 1 clears, write 0 has no effect.
  - Any other offset: read 0, write ignored, still acknowledged.
- Writes honour `iomem_wstrb` per byte. A byte lane of STATUS or CTRL outside the implemented bits is ignored.
- Prescaler:
  - Counts 0..PRESCALE while `EN`=1 and emits `tick` when `pcnt==PRESCALE`, then wraps to 0.
  - PRESCALE=0 gives a tick every cycle.
  - `EN`=0 holds `pcnt` at 0.
- On `tick`:
  - If `COUNT==COMPARE`: set `MATCH`, load `COUNT<=0`, and if `AUTO`=0 clear `EN`.
  - Otherwise `COUNT<=COUNT+1`, wrapping modulo 2^32.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as `tick` wins over the increment/reload.
  - A match set in the same cycle as a STATUS clear wins, so `MATCH` stays 1.
  - A CTRL write in the same cycle as a one-shot auto-clear of `EN` wins.
- Reads return register contents as of the request cycle.

## Timing
- Bus FSM, two states:
  - IDLE → ACK on a hit with `iomem_ready`=0.
  - ACK → IDLE unconditionally.
- `iomem_ready` is registered: high exactly 1 cycle, on the cycle after the first hit cycle.
- The write takes effect on the same edge that raises `iomem_ready`; it is never repeated even if `iomem_valid` is held through the ACK cycle.
- `iomem_rdata` is registered alongside `iomem_ready`.
- `irq` is combinational from registered `MATCH`/`IRQ_EN`, so it rises 1 cycle after the match tick.
- Reset: every register, `pcnt`, FSM, `iomem_ready`, `iomem_rdata` and `irq` go to 0 immediately (asynchronous).
- A reset mid-transaction drops the acknowledge; the master re-issues.

## Structure
- Package `iomem_timer_pkg`:
  - register offsets (`TMR_CTRL`=0x00 … `TMR_STATUS`=0x10);
  - CTRL bit indices;
  - a 2-state bus FSM enum.
- Sub-module `iomem_timer_prescaler`:
  - inputs: `clk`, `reset`, `en`, `clr`, `prescale[15:0]`;
  - output: `tick`.
- Register file, compare logic and bus FSM live in the top level.

## Test plan
- Reset mid-run: assert `reset` with `EN`=1 → all reads return 0, `irq`=0, and `iomem_ready` is not asserted in the reset cycle.
- Read and write: write 0x12345678 to COMPARE, then read it back; write `wstrb`=4'b0010, data 0xAA00 → COMPARE=0x1234AA78. In both cases `iomem_ready` is high 1 cycle, one cycle after `iomem_valid`.
- Auto-reload: PRESCALE=0, COMPARE=3, CTRL=0x7 → `MATCH` sets every 4 ticks; `irq` rises 1 cycle after each match tick; writing STATUS=1 clears `irq`.
- One-shot with prescale: PRESCALE=2, COMPARE=1, CTRL=0x5 → the match occurs after 6 clocks, `EN` reads 0 afterwards, and COUNT holds at 0.
- Collisions:
  - STATUS clear coinciding with a match tick → `MATCH` stays 1.
  - COUNT write of 0x10 coinciding with a tick → COUNT=0x10.
- Decode: an address outside the window gets no `iomem_ready` for 20 cycles; offset 0x40 reads 0 and is acknowledged; a held `iomem_valid` is acknowledged once per 2-cycle request.
